axi_10g_ethernet_0_rx_resize: RTL and testbench

//  Realigns the TCP payload stream from the RX parser onto 8-byte sequence-word boundaries for the RX store.

---
 rtl/axi_10g_tcp_pkg.sv | 38 +++
 rtl/axi_10g_ethernet_0_rx_lane_rotate.sv | 23 ++
 rtl/axi_10g_ethernet_0_rx_resize.sv | 183 ++++++++++++++++++
 tb/tb_axi_10g_ethernet_0_rx_resize.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_10g_tcp_pkg.sv
// Shared definitions for the TCP RX datapath blocks.
//   BYTES_PER_BEAT / SEQ_W : stream geometry
//   rs_state_e             : resize FSM states
//   seq_bswap32            : wire-order <-> numeric sequence number
//   keep_popcount8         : number of set bits in an 8-bit tkeep
//   lane_mask(lo,hi)       : lanes lo..hi set (empty when hi < lo)
package axi_10g_tcp_pkg;

  localparam int BYTES_PER_BEAT = 8;
  localparam int SEQ_W          = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2
  } rs_state_e;

  function automatic logic [31:0] seq_bswap32(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [3:0] keep_popcount8(input logic [7:0] k);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + 4'(k[i]);
    return c;
  endfunction

  function automatic logic [7:0] lane_mask(input logic [3:0] lo, input logic [3:0] hi);
    logic [7:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if ((4'(i) >= lo) && (4'(i) <= hi)) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_rx_lane_rotate.sv
// Combinational byte rotate-left: input byte i lands in lane (i + rot) mod 8.
//   data    : 64-bit beat, byte 0 in [7:0]
//   rot     : rotate amount in bytes
//   rotated : rotated beat
module axi_10g_ethernet_0_rx_lane_rotate
  import axi_10g_tcp_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  rot,
  output logic [63:0] rotated
);

  always_comb begin
    logic [2:0] dst;
    rotated = '0;
    dst     = '0;
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      dst = 3'(i) + rot;
      rotated[{dst, 3'b000} +: 8] = data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/axi_10g_ethernet_0_rx_resize.sv
// Realigns the TCP RX payload stream so that sequence byte s sits in lane
// s[2:0]; each output beat carries bytes of a single 8-byte sequence word.
//   aclk / areset_n                  : clock, async active-low reset
//   established_moment               : sync clear of carry, pointer and FSM
//   rx_not_stored_user_*             : upstream payload stream (in)
//   seq_number_store                 : seq of first payload byte of a segment
//   rx_not_stored_user_*_resize      : aligned stream towards the RX store
//   seq_number_store_resize          : numeric seq of lowest valid byte in beat
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a valid output holds data, keep and seq stable until taken.
module axi_10g_ethernet_0_rx_resize
  import axi_10g_tcp_pkg::*;
#(
  parameter bit SEQ_SWAP = 1'b1
) (
  input  logic             aclk,
  input  logic             areset_n,
  input  logic             established_moment,
  input  logic             rx_not_stored_user_tvalid,
  output logic             rx_not_stored_user_tready,
  input  logic [63:0]      rx_not_stored_user_tdata,
  input  logic [7:0]       rx_not_stored_user_tkeep,
  input  logic             rx_not_stored_user_tlast,
  input  logic [SEQ_W-1:0] seq_number_store,
  output logic             rx_not_stored_user_tvalid_resize,
  input  logic             rx_not_stored_user_tready_resize,
  output logic [63:0]      rx_not_stored_user_tdata_resize,
  output logic [7:0]       rx_not_stored_user_tkeep_resize,
  output logic [SEQ_W-1:0] seq_number_store_resize
);

  rs_state_e        state, state_nxt;
  logic [SEQ_W-1:0] ptr, ptr_nxt;
  logic [63:0]      carry_data, carry_data_nxt;
  logic [7:0]       carry_keep, carry_keep_nxt;
  logic [SEQ_W-1:0] carry_seq, carry_seq_nxt;
  logic             out_valid, out_valid_nxt;
  logic [63:0]      out_data, out_data_nxt;
  logic [7:0]       out_keep, out_keep_nxt;
  logic [SEQ_W-1:0] out_seq, out_seq_nxt;

  logic             out_free, accept;
  logic [SEQ_W-1:0] seq_num, base, next_word_seq;
  logic [2:0]       o;
  logic [3:0]       n, total;
  logic             complete;
  logic [63:0]      rotated, cur_bytes, ovf_bytes, word_data;
  logic [7:0]       cur_mask, ovf_mask, word_keep;
  logic [SEQ_W-1:0] word_seq;

  assign out_free = !out_valid | rx_not_stored_user_tready_resize;
  assign rx_not_stored_user_tready = out_free & (state != ST_FLUSH);
  assign accept = rx_not_stored_user_tvalid & rx_not_stored_user_tready;

  assign seq_num = SEQ_SWAP ? seq_bswap32(seq_number_store) : seq_number_store;
  // The segment's pointer is taken from the input only on its first beat.
  assign base  = (state == ST_IDLE) ? seq_num : ptr;
  assign o     = base[2:0];
  assign n     = keep_popcount8(rx_not_stored_user_tkeep);
  assign total = {1'b0, o} + n;
  assign complete = (total >= 4'd8);
  assign next_word_seq = {base[SEQ_W-1:3] + 29'd1, 3'b000};

  axi_10g_ethernet_0_rx_lane_rotate u_rotate (
    .data    (rx_not_stored_user_tdata),
    .rot     (o),
    .rotated (rotated)
  );

  // Lanes of the current word filled by this beat, and lanes spilling into
  // the next word.
  always_comb begin
    cur_mask  = '0;
    ovf_mask  = '0;
    cur_bytes = '0;
    ovf_bytes = '0;
    if (n != 4'd0) cur_mask = lane_mask({1'b0, o}, complete ? 4'd7 : total - 4'd1);
    if (total > 4'd8) ovf_mask = lane_mask(4'd0, total - 4'd9);
    for (int i = 0; i < BYTES_PER_BEAT; i++) begin
      cur_bytes[i*8 +: 8] = {8{cur_mask[i]}};
      ovf_bytes[i*8 +: 8] = {8{ovf_mask[i]}};
    end
  end

  // Carry data is kept zero outside its keep lanes, so a plain OR merges.
  assign word_data = carry_data | (rotated & cur_bytes);
  assign word_keep = carry_keep | cur_mask;
  assign word_seq  = (carry_keep != 8'h00) ? carry_seq : base;

  always_comb begin
    state_nxt      = state;
    ptr_nxt        = ptr;
    carry_data_nxt = carry_data;
    carry_keep_nxt = carry_keep;
    carry_seq_nxt  = carry_seq;
    out_valid_nxt  = out_valid & !rx_not_stored_user_tready_resize;
    out_data_nxt   = out_data;
    out_keep_nxt   = out_keep;
    out_seq_nxt    = out_seq;

    if (established_moment) begin
      // Takes priority over any beat accepted this cycle; that beat is dropped.
      state_nxt      = ST_IDLE;
      ptr_nxt        = '0;
      carry_data_nxt = '0;
      carry_keep_nxt = '0;
      carry_seq_nxt  = '0;
      out_valid_nxt  = 1'b0;
    end else if (state == ST_FLUSH) begin
      if (out_free) begin
        out_valid_nxt  = 1'b1;
        out_data_nxt   = carry_data;
        out_keep_nxt   = carry_keep;
        out_seq_nxt    = carry_seq;
        carry_data_nxt = '0;
        carry_keep_nxt = '0;
        state_nxt      = ST_IDLE;
      end
    end else if (accept) begin
      ptr_nxt = base + {28'd0, n};
      if (complete) begin
        out_valid_nxt  = 1'b1;
        out_data_nxt   = word_data;
        out_keep_nxt   = word_keep;
        out_seq_nxt    = word_seq;
        carry_data_nxt = rotated & ovf_bytes;
        carry_keep_nxt = ovf_mask;
        carry_seq_nxt  = next_word_seq;
        if (rx_not_stored_user_tlast) begin
          state_nxt = (ovf_mask != 8'h00) ? ST_FLUSH : ST_IDLE;
        end else begin
          state_nxt = ST_STREAM;
        end
      end else if (rx_not_stored_user_tlast) begin
        // Partial word at segment end goes out directly, no flush cycle.
        if (word_keep != 8'h00) begin
          out_valid_nxt = 1'b1;
          out_data_nxt  = word_data;
          out_keep_nxt  = word_keep;
          out_seq_nxt   = word_seq;
        end
        carry_data_nxt = '0;
        carry_keep_nxt = '0;
        state_nxt      = ST_IDLE;
      end else begin
        carry_data_nxt = word_data;
        carry_keep_nxt = word_keep;
        carry_seq_nxt  = word_seq;
        state_nxt      = ST_STREAM;
      end
    end
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      carry_data <= '0;
      carry_keep <= '0;
      carry_seq  <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_keep   <= '0;
      out_seq    <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      carry_data <= carry_data_nxt;
      carry_keep <= carry_keep_nxt;
      carry_seq  <= carry_seq_nxt;
      out_valid  <= out_valid_nxt;
      out_data   <= out_data_nxt;
      out_keep   <= out_keep_nxt;
      out_seq    <= out_seq_nxt;
    end
  end

  assign rx_not_stored_user_tvalid_resize = out_valid;
  assign rx_not_stored_user_tdata_resize  = out_data;
  assign rx_not_stored_user_tkeep_resize  = out_keep;
  assign seq_number_store_resize          = out_seq;

endmodule

// File: tb/tb_axi_10g_ethernet_0_rx_resize.sv
// Bench for axi_10g_ethernet_0_rx_resize: segments are driven beat by beat,
// a byte-level model groups payload bytes into sequence words and pushes the
// expected aligned beats into exp_q; a monitor pops and compares every beat
// the DUT hands downstream.
module tb_axi_10g_ethernet_0_rx_resize;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic        established_moment;
  logic        rx_not_stored_user_tvalid;
  logic        rx_not_stored_user_tready;
  logic [63:0] rx_not_stored_user_tdata;
  logic [7:0]  rx_not_stored_user_tkeep;
  logic        rx_not_stored_user_tlast;
  logic [31:0] seq_number_store;
  logic        rx_not_stored_user_tvalid_resize;
  logic        rx_not_stored_user_tready_resize;
  logic [63:0] rx_not_stored_user_tdata_resize;
  logic [7:0]  rx_not_stored_user_tkeep_resize;
  logic [31:0] seq_number_store_resize;

  always #5 aclk = ~aclk;

  axi_10g_ethernet_0_rx_resize #(.SEQ_SWAP(1'b1)) dut (
    .aclk                             (aclk),
    .areset_n                         (areset_n),
    .established_moment               (established_moment),
    .rx_not_stored_user_tvalid        (rx_not_stored_user_tvalid),
    .rx_not_stored_user_tready        (rx_not_stored_user_tready),
    .rx_not_stored_user_tdata         (rx_not_stored_user_tdata),
    .rx_not_stored_user_tkeep         (rx_not_stored_user_tkeep),
    .rx_not_stored_user_tlast         (rx_not_stored_user_tlast),
    .seq_number_store                 (seq_number_store),
    .rx_not_stored_user_tvalid_resize (rx_not_stored_user_tvalid_resize),
    .rx_not_stored_user_tready_resize (rx_not_stored_user_tready_resize),
    .rx_not_stored_user_tdata_resize  (rx_not_stored_user_tdata_resize),
    .rx_not_stored_user_tkeep_resize  (rx_not_stored_user_tkeep_resize),
    .seq_number_store_resize          (seq_number_store_resize)
  );

  int vectors    = 0;
  int miscompares = 0;

  // Expected beat: {seq[31:0], keep[7:0], data[63:0]} with unkept lanes zero.
  logic [103:0] exp_q[$];
  logic [103:0] exp_item, got_item, held_val;
  logic [63:0]  got_data;
  bit           held_v   = 1'b0;
  bit           cnt_en   = 1'b0;
  bit           bp_watch = 1'b0;
  int           low_cnt  = 0;

  logic [63:0] seg_data[8];
  logic [7:0]  seg_keep[8];
  int          seg_len;

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  // Monitor / scoreboard, sampled mid-cycle.
  always @(negedge aclk) begin
    if (areset_n && rx_not_stored_user_tvalid_resize) begin
      got_data = '0;
      for (int i = 0; i < 8; i++)
        if (rx_not_stored_user_tkeep_resize[i])
          got_data[i*8 +: 8] = rx_not_stored_user_tdata_resize[i*8 +: 8];
      got_item = {seq_number_store_resize, rx_not_stored_user_tkeep_resize, got_data};
      if (rx_not_stored_user_tready_resize) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_beat: got seq=%h keep=%h data=%h, required no beat",
                   got_item[103:72], got_item[71:64], got_item[63:0]);
        end else begin
          exp_item = exp_q.pop_front();
          if (got_item !== exp_item) begin
            miscompares++;
            $display("FAIL out_beat: got seq=%h keep=%h data=%h, required seq=%h keep=%h data=%h",
                     got_item[103:72], got_item[71:64], got_item[63:0],
                     exp_item[103:72], exp_item[71:64], exp_item[63:0]);
          end
        end
        held_v = 1'b0;
      end else begin
        if (held_v) begin
          vectors++;
          if (got_item !== held_val) begin
            miscompares++;
            $display("FAIL hold_stable: got %h, required %h", got_item, held_val);
          end
        end
        held_v   = 1'b1;
        held_val = got_item;
        if (bp_watch) begin
          vectors++;
          if (rx_not_stored_user_tready !== 1'b0) begin
            miscompares++;
            $display("FAIL tready_in_stall: got %b, required 0", rx_not_stored_user_tready);
          end
        end
      end
    end else begin
      held_v = 1'b0;
    end
    if (cnt_en && !rx_not_stored_user_tready) low_cnt++;
  end

  // Byte-level reference: walk payload bytes in order, group by word index.
  task automatic model_segment(input logic [31:0] seq0, input bit drop_tail);
    logic [31:0] s;
    logic [28:0] cur_w;
    logic [63:0] d;
    logic [7:0]  k;
    logic [31:0] wseq;
    bit          open;
    s = seq0; open = 1'b0; cur_w = '0; d = '0; k = '0; wseq = '0;
    for (int b = 0; b < seg_len; b++) begin
      for (int i = 0; i < 8; i++) begin
        if (seg_keep[b][i]) begin
          if (open && (s[31:3] != cur_w)) begin
            exp_q.push_back({wseq, k, d});
            open = 1'b0;
          end
          if (!open) begin
            open = 1'b1; cur_w = s[31:3]; d = '0; k = '0; wseq = s;
          end
          d[{s[2:0], 3'b000} +: 8] = seg_data[b][i*8 +: 8];
          k[s[2:0]] = 1'b1;
          s = s + 32'd1;
        end
      end
    end
    if (open && !(drop_tail && (k != 8'hFF))) exp_q.push_back({wseq, k, d});
  endtask

  task automatic drive_beat(input logic [63:0] d, input logic [7:0] k, input bit l,
                            input logic [31:0] seq_raw);
    int t;
    bit ok;
    t = 0; ok = 1'b0;
    rx_not_stored_user_tvalid = 1'b1;
    rx_not_stored_user_tdata  = d;
    rx_not_stored_user_tkeep  = k;
    rx_not_stored_user_tlast  = l;
    seq_number_store          = seq_raw;
    while (!ok && t < 200) begin
      @(negedge aclk);
      ok = rx_not_stored_user_tready;
      @(posedge aclk);
      #1;
      t++;
    end
    rx_not_stored_user_tvalid = 1'b0;
    rx_not_stored_user_tdata  = '0;
    rx_not_stored_user_tkeep  = '0;
    rx_not_stored_user_tlast  = 1'b0;
    if (!ok) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: tready stayed %b for 200 cycles, required 1", rx_not_stored_user_tready);
    end
  endtask

  task automatic drive_segment(input logic [31:0] seq0);
    for (int b = 0; b < seg_len; b++)
      drive_beat(seg_data[b], seg_keep[b], (b == seg_len - 1), bswap(seq0));
  endtask

  task automatic fill_segment(input int len, input logic [7:0] k0, input logic [7:0] k1,
                              input logic [7:0] k2);
    seg_len = len;
    for (int b = 0; b < 8; b++) begin
      seg_data[b] = {$urandom, $urandom};
      seg_keep[b] = 8'hFF;
    end
    seg_keep[0] = k0;
    seg_keep[1] = k1;
    seg_keep[2] = k2;
  endtask

  task automatic wait_drain(input string name);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 100) begin
      @(posedge aclk);
      t++;
    end
    repeat (4) @(posedge aclk);
    #1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    vectors += 5;
    if (rx_not_stored_user_tready !== 1'b1) begin
      miscompares++; $display("FAIL reset_tready: got %b, required 1", rx_not_stored_user_tready);
    end
    if (rx_not_stored_user_tvalid_resize !== 1'b0) begin
      miscompares++; $display("FAIL reset_valid: got %b, required 0", rx_not_stored_user_tvalid_resize);
    end
    if (rx_not_stored_user_tdata_resize !== 64'd0) begin
      miscompares++; $display("FAIL reset_data: got %h, required 0", rx_not_stored_user_tdata_resize);
    end
    if (rx_not_stored_user_tkeep_resize !== 8'd0) begin
      miscompares++; $display("FAIL reset_keep: got %h, required 0", rx_not_stored_user_tkeep_resize);
    end
    if (seq_number_store_resize !== 32'd0) begin
      miscompares++; $display("FAIL reset_seq: got %h, required 0", seq_number_store_resize);
    end
    @(posedge aclk);
    #1 areset_n = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
  endtask

  task automatic test_aligned();
    fill_segment(3, 8'hFF, 8'hFF, 8'h0F);
    model_segment(32'h0000_1000, 1'b0);
    drive_segment(32'h0000_1000);
    wait_drain("aligned");
  endtask

  task automatic test_misaligned();
    fill_segment(2, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'h0000_1003, 1'b0);
    low_cnt = 0;
    cnt_en  = 1'b1;
    drive_segment(32'h0000_1003);
    wait_drain("misaligned");
    cnt_en = 1'b0;
    vectors++;
    if (low_cnt != 1) begin
      miscompares++;
      $display("FAIL flush_tready_low: got %0d cycles, required 1", low_cnt);
    end
  endtask

  task automatic test_short();
    fill_segment(1, 8'h03, 8'hFF, 8'hFF);
    model_segment(32'h0000_2005, 1'b0);
    drive_segment(32'h0000_2005);
    wait_drain("short");
  endtask

  task automatic test_wrap();
    fill_segment(1, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'hFFFF_FFFC, 1'b0);
    drive_segment(32'hFFFF_FFFC);
    wait_drain("wrap");
  endtask

  task automatic test_backpressure();
    fill_segment(2, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'h0000_1003, 1'b0);
    bp_watch = 1'b1;
    fork
      drive_segment(32'h0000_1003);
      begin
        repeat (2) @(posedge aclk);
        #1 rx_not_stored_user_tready_resize = 1'b0;
        repeat (5) @(posedge aclk);
        #1 rx_not_stored_user_tready_resize = 1'b1;
      end
    join
    wait_drain("backpressure");
    bp_watch = 1'b0;
  endtask

  task automatic test_establish();
    fill_segment(1, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'h0000_3003, 1'b1);
    drive_beat(seg_data[0], seg_keep[0], 1'b0, bswap(32'h0000_3003));
    @(posedge aclk);
    #1 established_moment = 1'b1;
    @(posedge aclk);
    #1 established_moment = 1'b0;
    wait_drain("establish_cut");
    fill_segment(1, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'h0000_4000, 1'b0);
    drive_segment(32'h0000_4000);
    wait_drain("establish_next");
  endtask

  task automatic test_reset_in_flush();
    fill_segment(2, 8'hFF, 8'hFF, 8'hFF);
    model_segment(32'h0000_1003, 1'b1);
    drive_segment(32'h0000_1003);
    @(negedge aclk);
    vectors++;
    if (rx_not_stored_user_tready !== 1'b0) begin
      miscompares++; $display("FAIL flush_entry_tready: got %b, required 0", rx_not_stored_user_tready);
    end
    #1 areset_n = 1'b0;
    #1;
    vectors += 2;
    if (rx_not_stored_user_tvalid_resize !== 1'b0) begin
      miscompares++; $display("FAIL async_reset_valid: got %b, required 0", rx_not_stored_user_tvalid_resize);
    end
    if (rx_not_stored_user_tready !== 1'b1) begin
      miscompares++; $display("FAIL async_reset_tready: got %b, required 1", rx_not_stored_user_tready);
    end
    @(posedge aclk);
    #1 areset_n = 1'b1;
    wait_drain("reset_in_flush");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    areset_n                         = 1'b0;
    established_moment               = 1'b0;
    rx_not_stored_user_tvalid        = 1'b0;
    rx_not_stored_user_tdata         = '0;
    rx_not_stored_user_tkeep         = '0;
    rx_not_stored_user_tlast         = 1'b0;
    seq_number_store                 = '0;
    rx_not_stored_user_tready_resize = 1'b1;
    seg_len                          = 0;

    test_reset();
    test_aligned();
    test_misaligned();
    test_short();
    test_wrap();
    test_backpressure();
    test_establish();
    test_reset_in_flush();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
